// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the slide-switch debouncer.
package sw_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } bit_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: multi-flop synchronizer, STABLE/CHANGING debounce FSM and
// stability counter. commit_o flags the edge on which out_o takes a new level.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RST_BIT         = 1'b0
) (
    input  logic clk,
    input  logic R_n,
    input  logic sw_i,
    output logic out_o,
    output logic commit_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    bit_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic                   out_q;
    logic                   commit_d;

    // Stage 0 is the metastability catcher; only the last stage feeds the FSM.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            sync_q <= {SYNC_STAGES{RST_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
        end
    end

    assign sync     = sync_q[SYNC_STAGES-1];
    assign commit_d = (state_q == CHANGING) && (sync != out_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            out_q   <= RST_BIT;
        end else begin
            case (state_q)
                STABLE: begin
                    if (sync != out_q) begin
                        state_q <= CHANGING;
                        cnt_q   <= CW'(1);
                    end
                end
                CHANGING: begin
                    if (sync == out_q) begin
                        // Bounced back: abandon the candidate level.
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (commit_d) begin
                        out_q   <= sync;
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign out_o    = out_q;
    assign commit_o = commit_d;

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch vector with a registered change strobe.
// Define SW_DEBOUNCE_EDGE_EN to add per-bit sw_rise/sw_fall commit pulses.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             R_n,
    input  logic [WIDTH-1:0] sw_in,
`ifdef SW_DEBOUNCE_EDGE_EN
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`endif
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_changed
);

    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] commit_w;
    logic             sw_changed_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            sw_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RST_BIT         (RESET_VAL[gi])
            ) u_bit (
                .clk      (clk),
                .R_n      (R_n),
                .sw_i     (sw_in[gi]),
                .out_o    (out_w[gi]),
                .commit_o (commit_w[gi])
            );
        end
    endgenerate

    // Commit flags are next-edge indicators, so this pulse lines up with sw_out.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            sw_changed_q <= 1'b0;
        end else begin
            sw_changed_q <= |commit_w;
        end
    end

    assign sw_out     = out_w;
    assign sw_changed = sw_changed_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // A committing bit always flips, so its current level gives the direction.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= commit_w & ~out_w;
            fall_q <= commit_w & out_w;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=8 (commit on 10th edge).
module tb_sw_debounce;

    localparam int WIDTH = 2;

    logic             clk;
    logic             R_n;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             sw_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int pulse_cnt = 0;

    sw_debounce #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .RESET_VAL       (2'b00)
    ) dut (
        .clk        (clk),
        .R_n        (R_n),
        .sw_in      (sw_in),
`ifdef SW_DEBOUNCE_EDGE_EN
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
`endif
        .sw_out     (sw_out),
        .sw_changed (sw_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sw_changed) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int   p0;
    logic bad;

    initial begin
        // Reset with switches high: outputs held at RESET_VAL.
        R_n   = 1'b0;
        sw_in = 2'b11;
        tick(3);
        check("rst_out", 32'(sw_out), 32'h0);
        check("rst_chg", 32'(sw_changed), 32'h0);
        R_n = 1'b1;
        p0  = pulse_cnt;
        tick(9);
        check("rel_edge9_out", 32'(sw_out), 32'h0);
        tick(1);
        check("rel_edge10_out", 32'(sw_out), 32'h3);
        check("rel_edge10_chg", 32'(sw_changed), 32'h1);
        tick(1);
        check("rel_chg_drop", 32'(sw_changed), 32'h0);
        check("rel_pulses", 32'(pulse_cnt - p0), 32'h1);

        // Bounce on bit 0: toggles every 3 cycles never settle long enough.
        R_n   = 1'b0;
        sw_in = 2'b00;
        tick(2);
        R_n = 1'b1;
        tick(3);
        p0  = pulse_cnt;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sw_in[0] = ~sw_in[0];
            for (int j = 0; j < 3; j++) begin
                tick(1);
                bad = bad | sw_out[0];
            end
        end
        check("bounce_held", 32'(bad), 32'h0);
        sw_in[0] = 1'b1;
        tick(9);
        check("bounce_edge9", 32'(sw_out), 32'h0);
        tick(1);
        check("bounce_edge10", 32'(sw_out), 32'h1);
        tick(1);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'h1);

        // Glitch of 7 cycles on bit 1: one short of commit.
        p0    = pulse_cnt;
        sw_in = 2'b11;
        tick(7);
        sw_in = 2'b01;
        tick(20);
        check("glitch_out", 32'(sw_out), 32'h1);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'h0);

        // Both bits rising together produce one pulse.
        R_n   = 1'b0;
        sw_in = 2'b00;
        tick(2);
        R_n = 1'b1;
        tick(3);
        p0    = pulse_cnt;
        sw_in = 2'b11;
        tick(9);
        check("simul_edge9", 32'(sw_out), 32'h0);
        tick(1);
        check("simul_edge10", 32'(sw_out), 32'h3);
        check("simul_chg", 32'(sw_changed), 32'h1);
        tick(1);
        check("simul_chg_drop", 32'(sw_changed), 32'h0);
        check("simul_pulses", 32'(pulse_cnt - p0), 32'h1);

        // Reset while bit 0 is mid-count (cnt=5) must clear at once.
        sw_in = 2'b10;
        tick(7);
        check("mid_pre", 32'(sw_out), 32'h3);
        R_n = 1'b0;
        #1;
        check("mid_async_out", 32'(sw_out), 32'h0);
        sw_in = 2'b01;
        tick(2);
        R_n = 1'b1;
        p0  = pulse_cnt;
        tick(9);
        check("mid_edge9", 32'(sw_out), 32'h0);
        tick(1);
        check("mid_edge10", 32'(sw_out), 32'h1);
        check("mid_chg", 32'(sw_changed), 32'h1);

        // Rising then falling commit on bit 0.
        R_n   = 1'b0;
        sw_in = 2'b00;
        tick(1);
        R_n = 1'b1;
        tick(3);
        sw_in = 2'b01;
        tick(10);
        check("rise_out", 32'(sw_out), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("rise_pulse", 32'(sw_rise), 32'h1);
        check("rise_nofall", 32'(sw_fall), 32'h0);
`endif
        tick(1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("rise_drop", 32'(sw_rise), 32'h0);
`endif
        sw_in = 2'b00;
        tick(10);
        check("fall_out", 32'(sw_out), 32'h0);
        check("fall_chg", 32'(sw_changed), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("fall_pulse", 32'(sw_fall), 32'h1);
        check("fall_norise", 32'(sw_rise), 32'h0);
`endif
        tick(1);
        check("fall_chg_drop", 32'(sw_changed), 32'h0);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("fall_drop", 32'(sw_fall), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
